// File: rtl/hamming_pkg.sv
// Shared Hamming decoder definitions: FSM encoding, N/K/L derivation and data-position mapping.
// HAMMING_DEC_SECDED_EN adds the trailing overall-parity bit (L = N + 1).
package hamming_pkg;

  localparam int R_MIN = 3;
  localparam int R_MAX = 5;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } dec_state_t;

  function automatic int calc_n(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int calc_k(input int r);
    return calc_n(r) - r;
  endfunction

  function automatic int calc_l(input int r);
`ifdef HAMMING_DEC_SECDED_EN
    return calc_n(r) + 1;
`else
    return calc_n(r);
`endif
  endfunction

  function automatic bit is_pow2(input int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Codeword position of data bit idx: non-power-of-two positions in ascending order.
  function automatic int data_pos(input int r, input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= calc_n(r); p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational syndrome / overall parity / single-bit correction of a buffered codeword.
// Bit p of codeword holds position p; bit 0 is the overall-parity slot.
module hamming_syndrome_calc
  import hamming_pkg::*;
#(
  parameter  int R = 3,
  localparam int N = calc_n(R)
) (
  input  logic [N:0]   codeword,
  output logic [R-1:0] syndrome,
  output logic         parity_odd,
  output logic [N:0]   corrected
);

  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= N; p++) begin
      if (codeword[p]) syndrome = syndrome ^ R'(p);
    end
    parity_odd = ^codeword;
    corrected  = codeword;
    if (syndrome != '0) corrected[syndrome] = ~codeword[syndrome];
  end

endmodule

// File: rtl/tt_um_hamming_decoder_gen.sv
// Serial-in Hamming SEC decoder with registered, back-pressured word output.
// Define HAMMING_DEC_SECDED_EN for SECDED (extra overall-parity bit, double-error flag).
module tt_um_hamming_decoder_gen
  import hamming_pkg::*;
#(
  parameter  int R = 3,
  localparam int N = calc_n(R),
  localparam int K = calc_k(R),
  localparam int L = calc_l(R)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         sync_clr,
  input  logic         decode_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [K-1:0] decode_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err_corrected,
  output logic         err_uncorrectable,
  output logic [R-1:0] debug_syndrome_out,
  output logic [R:0]   debug_counter_out
);

  localparam int CW = R + 1;

  dec_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N:0]    cw_buf;
  logic [R-1:0]  syn;
  logic          par_odd;
  logic [N:0]    cw_fix;
  logic [N:0]    word_fix;
  logic [K-1:0]  data_fix;
  logic          flag_cor, flag_unc;
  logic [R-1:0]  bit_pos;
  logic          accept, last_bit, slot_free, xfer;

  assign in_ready  = (state == COLLECT);
  assign slot_free = ~out_valid | out_ready;
  assign accept    = ena & ~sync_clr & in_valid & in_ready;
  assign last_bit  = (cnt == CW'(L - 1));
  assign xfer      = ena & ~sync_clr & (state == FULL) & slot_free;
  // Bits arrive as positions 1..N; the optional parity bit (count N) lands in slot 0.
  assign bit_pos   = (cnt == CW'(N)) ? '0 : R'(cnt + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ena) begin
      if (sync_clr) state_nxt = COLLECT;
      else begin
        case (state)
          COLLECT: if (accept && last_bit) state_nxt = FULL;
          FULL:    if (slot_free) state_nxt = COLLECT;
          default: state_nxt = COLLECT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      cw_buf <= '0;
    end else if (ena) begin
      if (sync_clr) cnt <= '0;
      else if (accept) begin
        cw_buf[bit_pos] <= decode_in;
        cnt             <= last_bit ? '0 : cnt + 1'b1;
      end
    end
  end

  hamming_syndrome_calc #(.R(R)) u_syn (
    .codeword   (cw_buf),
    .syndrome   (syn),
    .parity_odd (par_odd),
    .corrected  (cw_fix)
  );

  always_comb begin
    word_fix = cw_buf;
    flag_cor = 1'b0;
    flag_unc = 1'b0;
`ifdef HAMMING_DEC_SECDED_EN
    // Even overall parity with nonzero syndrome means two flips: report, don't "fix".
    if (syn != '0) begin
      if (par_odd) begin
        word_fix = cw_fix;
        flag_cor = 1'b1;
      end else begin
        flag_unc = 1'b1;
      end
    end else if (par_odd) begin
      flag_cor = 1'b1;
    end
`else
    if (syn != '0) begin
      word_fix = cw_fix;
      flag_cor = 1'b1;
    end
`endif
  end

  for (genvar g = 0; g < K; g++) begin : g_data
    localparam int P = data_pos(R, g);
    assign data_fix[g] = word_fix[P];
  end

  // Parity positions of word_fix (and par_odd in the SEC build) are intentionally dropped.
  logic unused_ok;
  assign unused_ok = ^{word_fix, par_odd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decode_out        <= '0;
      out_valid         <= 1'b0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else if (ena) begin
      if (xfer) begin
        decode_out        <= data_fix;
        out_valid         <= 1'b1;
        err_corrected     <= flag_cor;
        err_uncorrectable <= flag_unc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign debug_syndrome_out = syn;
  assign debug_counter_out  = cnt;

endmodule

// File: tb/tb_tt_um_hamming_decoder_gen.sv
// Directed bench for tt_um_hamming_decoder_gen at R=3 and R=4 (SEC or SECDED build).
module tb_tt_um_hamming_decoder_gen;

`ifdef HAMMING_DEC_SECDED_EN
  localparam bit SECDED = 1'b1;
  localparam logic [15:0] CW4 = 16'hB42D;
`else
  localparam bit SECDED = 1'b0;
  localparam logic [15:0] CW4 = 16'hB42C;
`endif

  logic clk = 1'b0;
  logic rst_n, ena, sync_clr, out_ready;

  logic       in_valid3, decode_in3, in_ready3, out_valid3, ec3, eu3;
  logic [3:0] decode_out3;
  logic [2:0] syn3;
  logic [3:0] cnt3;

  logic        in_valid4, decode_in4, in_ready4, out_valid4, ec4, eu4;
  logic [10:0] decode_out4;
  logic [3:0]  syn4;
  logic [4:0]  cnt4;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tt_um_hamming_decoder_gen #(.R(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sync_clr(sync_clr),
    .decode_in(decode_in3), .in_valid(in_valid3), .in_ready(in_ready3),
    .decode_out(decode_out3), .out_valid(out_valid3), .out_ready(out_ready),
    .err_corrected(ec3), .err_uncorrectable(eu3),
    .debug_syndrome_out(syn3), .debug_counter_out(cnt3)
  );

  tt_um_hamming_decoder_gen #(.R(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sync_clr(sync_clr),
    .decode_in(decode_in4), .in_valid(in_valid4), .in_ready(in_ready4),
    .decode_out(decode_out4), .out_valid(out_valid4), .out_ready(out_ready),
    .err_corrected(ec4), .err_uncorrectable(eu4),
    .debug_syndrome_out(syn4), .debug_counter_out(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send3(input logic [7:0] cw);
    in_valid3 = 1'b1;
    for (int p = 1; p <= 7; p++) begin
      decode_in3 = cw[p];
      tick();
    end
    if (SECDED) begin
      decode_in3 = cw[0];
      tick();
    end
    in_valid3 = 1'b0;
  endtask

  task automatic send4(input logic [15:0] cw);
    in_valid4 = 1'b1;
    for (int p = 1; p <= 15; p++) begin
      decode_in4 = cw[p];
      tick();
    end
    if (SECDED) begin
      decode_in4 = cw[0];
      tick();
    end
    in_valid4 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; sync_clr = 1'b0; out_ready = 1'b1;
    in_valid3 = 1'b0; decode_in3 = 1'b0; in_valid4 = 1'b0; decode_in4 = 1'b0;
    #12;
    chk("rst_dout", 32'(decode_out3), 32'h0);
    chk("rst_oval", 32'(out_valid3), 32'h0);
    chk("rst_cnt", 32'(cnt3), 32'h0);
    chk("rst_cnt4", 32'(cnt4), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_irdy", 32'(in_ready3), 32'h1);
    chk("rst_irdy4", 32'(in_ready4), 32'h1);

    // clean word 1011 -> positions 1,3,5,7 set
    send3(8'hAA);
    chk("clean_lat_oval", 32'(out_valid3), 32'h0);
    chk("clean_full_irdy", 32'(in_ready3), 32'h0);
    tick();
    chk("clean_oval", 32'(out_valid3), 32'h1);
    chk("clean_dout", 32'(decode_out3), 32'hB);
    chk("clean_ec", 32'(ec3), 32'h0);
    chk("clean_eu", 32'(eu3), 32'h0);
    chk("clean_syn", 32'(syn3), 32'h0);

    // ena low freezes output handshake and counter
    ena = 1'b0; in_valid3 = 1'b1; decode_in3 = 1'b1;
    tick(); tick();
    chk("ena0_oval", 32'(out_valid3), 32'h1);
    chk("ena0_cnt", 32'(cnt3), 32'h0);
    in_valid3 = 1'b0; ena = 1'b1;
    tick();
    chk("drain_oval", 32'(out_valid3), 32'h0);

    // single error at position 6
    send3(8'hEA);
    tick();
    chk("se_syn", 32'(syn3), 32'h6);
    chk("se_dout", 32'(decode_out3), 32'hB);
    chk("se_ec", 32'(ec3), 32'h1);
    chk("se_eu", 32'(eu3), 32'h0);

`ifdef HAMMING_DEC_SECDED_EN
    // double error at positions 3 and 5: no correction
    send3(8'h82);
    tick();
    chk("de_syn", 32'(syn3), 32'h6);
    chk("de_eu", 32'(eu3), 32'h1);
    chk("de_ec", 32'(ec3), 32'h0);
    chk("de_dout", 32'(decode_out3), 32'h8);
    // overall-parity bit flipped only
    send3(8'hAB);
    tick();
    chk("pe_ec", 32'(ec3), 32'h1);
    chk("pe_eu", 32'(eu3), 32'h0);
    chk("pe_dout", 32'(decode_out3), 32'hB);
`endif

    // backpressure over two words: A=1011, B=0110
    tick();
    out_ready = 1'b0;
    send3(8'hAA);
    tick();
    chk("bp_a_oval", 32'(out_valid3), 32'h1);
    chk("bp_a_dout", 32'(decode_out3), 32'hB);
    send3(8'h66);
    tick(); tick();
    chk("bp_stall_irdy", 32'(in_ready3), 32'h0);
    chk("bp_stall_oval", 32'(out_valid3), 32'h1);
    chk("bp_stall_dout", 32'(decode_out3), 32'hB);
    out_ready = 1'b1;
    tick();
    chk("bp_b_oval", 32'(out_valid3), 32'h1);
    chk("bp_b_dout", 32'(decode_out3), 32'h6);
    chk("bp_b_ec", 32'(ec3), 32'h0);
    tick();
    chk("bp_done_oval", 32'(out_valid3), 32'h0);

    // sync_clr after 3 bits
    in_valid3 = 1'b1; decode_in3 = 1'b1;
    tick(); tick(); tick();
    in_valid3 = 1'b0;
    chk("sc_cnt3", 32'(cnt3), 32'h3);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    chk("sc_cnt0", 32'(cnt3), 32'h0);
    send3(8'hAA);
    tick();
    chk("sc_dout", 32'(decode_out3), 32'hB);
    chk("sc_ec", 32'(ec3), 32'h0);

    // reset mid-word with a flagged word held at the output
    send3(8'hEA);
    tick();
    in_valid3 = 1'b1; decode_in3 = 1'b1;
    tick(); tick(); tick(); tick();
    in_valid3 = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mr_dout", 32'(decode_out3), 32'h0);
    chk("mr_oval", 32'(out_valid3), 32'h0);
    chk("mr_ec", 32'(ec3), 32'h0);
    chk("mr_cnt", 32'(cnt3), 32'h0);
    chk("mr_syn", 32'(syn3), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mr_irdy", 32'(in_ready3), 32'h1);
    send3(8'h66);
    tick();
    chk("mr_next_dout", 32'(decode_out3), 32'h6);
    chk("mr_next_ec", 32'(ec3), 32'h0);

    // R=4: data 0x5A3, clean then every single-bit error position
    send4(CW4);
    tick();
    chk("r4_clean_dout", 32'(decode_out4), 32'h5A3);
    chk("r4_clean_ec", 32'(ec4), 32'h0);
    chk("r4_clean_syn", 32'(syn4), 32'h0);
    for (int p = 1; p <= 15; p++) begin
      send4(CW4 ^ (16'd1 << p));
      tick();
      chk($sformatf("r4_p%0d_dout", p), 32'(decode_out4), 32'h5A3);
      chk($sformatf("r4_p%0d_syn", p), 32'(syn4), 32'(p));
      chk($sformatf("r4_p%0d_ec", p), 32'(ec4), 32'h1);
      chk($sformatf("r4_p%0d_eu", p), 32'(eu4), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_um_hamming_decoder_gen.md
TT_UM_HAMMING_DECODER_GEN -- requirements
Module: tt_um_hamming_decoder_gen

Interface
REQ-001 SHALL have parameter R, default 3, number of Hamming parity bits (legal 3..5); N=2^R-1 code bits, K=N-R data bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-005 SHALL have port sync_clr  input  1  synchronous discard of partial codeword.
REQ-006 SHALL have port decode_in  input  1  serial code bit.
REQ-007 SHALL have port in_valid  input  1  decode_in qualifier.
REQ-008 SHALL have port in_ready  output  1  decoder accepts a bit this cycle.
REQ-009 SHALL have port decode_out  output  K  corrected data word.
REQ-010 SHALL have port out_valid  output  1  decode_out and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts word.
REQ-012 SHALL have port err_corrected  output  1  single error corrected in this word.
REQ-013 SHALL have port err_uncorrectable  output  1  double error detected (SECDED build only).
REQ-014 SHALL have ports debug_syndrome_out  output  R  and debug_counter_out  output  R+1  live syndrome / bit counter.

Function
REQ-015 SHALL receive codeword bits position 1 first through position N, then (SECDED build) overall-parity bit as position 0, L=N or N+1 bits per word.
REQ-016 SHALL place parity at power-of-two positions and data bits at remaining positions in ascending order, lowest position to decode_out[0].
REQ-017 SHALL accept a bit only in cycles with ena & in_valid & in_ready; counter increments per accepted bit, wraps L-1 -> 0.
REQ-018 SHALL use states COLLECT (accepting, in_ready=1) and FULL (word complete, in_ready=0, awaiting output slot).
REQ-019 SHALL go COLLECT->FULL on accepting bit L-1; FULL->COLLECT when output slot free (out_valid=0 or out_ready=1) with ena high.
REQ-020 SHALL, on that transfer, compute syndrome = XOR of positions of set bits, flip position syndrome if nonzero, load decode_out and flags, assert out_valid.
REQ-021 SHALL give latency of one cycle from last-bit acceptance to out_valid when slot free; back-to-back words with no bubble when out_ready held high.
REQ-022 SHALL hold decode_out, flags, out_valid stable while out_valid=1 and out_ready=0; clear out_valid on out_ready with no new word.
REQ-023 SHALL, in SECDED build: syn!=0 & parity odd -> correct, err_corrected=1; syn!=0 & parity even -> no correction, err_uncorrectable=1; syn=0 & parity odd -> err_corrected=1, data unchanged.
REQ-024 SHALL with sync_clr=1 (and ena=1) reset counter and state to COLLECT, dropping any same-cycle bit; output register unaffected.
REQ-025 SHALL with ena=0 ignore in_valid, out_ready and sync_clr and keep all state and outputs.

Reset
REQ-026 SHALL on rst_n low force: state COLLECT, counter 0, buffer 0, decode_out 0, out_valid 0, both flags 0; in_ready=1 after release.
REQ-027 SHALL discard any partial or pending word on reset mid-operation.

Configuration
REQ-028 SHALL compile the overall-parity (SECDED) feature when HAMMING_DEC_SECDED_EN is defined: L=N+1, REQ-023 active.
REQ-029 SHALL without HAMMING_DEC_SECDED_EN use L=N, SEC only, err_uncorrectable tied 0, port list unchanged.

Structure
REQ-030 SHALL place state encoding, L/N/K derivation helpers and position-to-data mapping constants in shared package hamming_pkg.
REQ-031 SHALL instantiate one combinational sub-module hamming_syndrome_calc (codeword in, syndrome and corrected codeword out).

Verification (R=3, data 4'b1011 -> codeword pos1..7 = 1,0,1,0,1,0,1, overall parity 0)
REQ-032 SHALL cover clean word: send 1,0,1,0,1,0,1(,0) -> out_valid next cycle, decode_out=1011, both flags 0.
REQ-033 SHALL cover single error: flip position 6 -> debug_syndrome_out=110, decode_out=1011, err_corrected=1.
REQ-034 SHALL cover double error (SECDED): flip positions 3 and 5 -> syndrome 110, err_uncorrectable=1, err_corrected=0.
REQ-035 SHALL cover backpressure: out_ready=0 over two words -> second word stalls in FULL, in_ready=0; out_ready=1 -> second word appears next cycle, no loss.
REQ-036 SHALL cover sync_clr after 3 bits then full clean word -> decode_out=1011; and rst_n pulse mid-word -> all outputs 0, next word decodes correctly.
REQ-037 SHALL cover R=4 (N=15, K=11) clean and single-error words for every error position 1..15.
